bp_be_issue_queue: RTL and testbench
====================================

Name: bp_be_issue_queue

Overview:
- Speculative instruction buffer directly upstream of the BE hazard detector. It accepts fetched instructions from the FE and presents the oldest un-issued instruction, with its pre-extracted register addresses, as issue-stage status.
- It pops on the detector's dispatch decision and holds issued entries until commit. A replay rewinds issue to the oldest uncommitted entry; a flush discards all entries.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p.
- els_p, 8, queue depth. Must be a power of two, at least 2.
- ptr_width_lp, $clog2(els_p)+1, derived. Pointer width, including one wrap bit.

Ports:
- clk_i  in  1  clock. All state updates on the rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- fe_v_i  in  1  FE instruction valid.
- fe_instr_i  in  32  instruction bits.
- fe_pc_i  in  vaddr_width_p  instruction PC.
- fe_ready_and_o  out  1  queue can accept an entry this cycle.
- isd_v_o  out  1  head (un-issued) entry valid.
- isd_instr_o  out  32  head instruction.
- isd_pc_o  out  vaddr_width_p  head PC.
- isd_rs1_addr_o  out  5  head instruction bits [19:15].
- isd_rs2_addr_o  out  5  head instruction bits [24:20].
- isd_rs3_addr_o  out  5  head instruction bits [31:27].
- isd_rd_addr_o  out  5  head instruction bits [11:7].
- dispatch_v_i  in  1  detector dispatches the head this cycle.
- commit_v_i  in  1  oldest issued entry retires.
- replay_v_i  in  1  rewind issue pointer to the oldest uncommitted entry.
- flush_v_i  in  1  discard all entries.
- occupancy_o  out  ptr_width_lp  number of entries held (issued plus un-issued).
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - Entry RAM of els_p x (32 + vaddr_width_p) flops; contents are not reset.
  - Three pointers, each ptr_width_lp wide: wptr (write), rptr (next to issue), cptr (oldest uncommitted).
  - err_r, one bit.
  - Index into the RAM with the low log2(els_p) bits. The MSB is the wrap bit.
- Reset (reset_n_i low, asynchronous): wptr=rptr=cptr=0, err_r=0. Outputs during reset: fe_ready_and_o=1, isd_v_o=0, occupancy_o=0, err_o=0.
- Derived signals, all combinational from registered state only:
  - occupancy_o = wptr - cptr, modulo 2^ptr_width_lp.
  - full = (occupancy_o == els_p); fe_ready_and_o = ~full.
  - isd_v_o = (rptr != wptr).
  - isd_* outputs read entry[rptr]. When isd_v_o=0 their values are don't-care.
- Enqueue: when fe_v_i & fe_ready_and_o, write entry[wptr] and increment wptr. The entry becomes visible at the head the next cycle (1-cycle latency, no bypass). fe_v_i while full is dropped and leaves state unchanged.
- Issue: when dispatch_v_i & isd_v_o & ~replay_v_i & ~flush_v_i, increment rptr. dispatch_v_i with isd_v_o=0 is ignored.
- Commit: when commit_v_i & ~flush_v_i, with cptr != rptr, increment cptr. A commit with cptr == rptr (no issued entry) is ignored and sets err_r.
- Replay: when replay_v_i & ~flush_v_i, rptr_next = cptr_next, i.e. cptr after any same-cycle commit. Same-cycle dispatch is ignored. Same-cycle enqueue proceeds.
- Flush: dominates everything else. wptr_next = rptr_next = cptr_next = wptr; any same-cycle enqueue is dropped; err_r is unchanged.
- Full boundary: fe_ready_and_o is based on current occupancy only. A same-cycle commit does not free space until the next cycle.
- Invariant: cptr <= rptr <= wptr in modular order. It holds under all legal and illegal input combinations above.
- err_r clears only on reset.

Test Plan:
- Ordering and reset outputs: reset, then enqueue PCs 0x100, 0x104, 0x108 on consecutive cycles with dispatch_v_i=1 every cycle. Required:
  - isd_v_o rises the cycle after the first enqueue; heads appear in order 0x100, 0x104, 0x108.
  - occupancy_o reaches 3 with no commits.
  - During reset: fe_ready_and_o=1, isd_v_o=0.
- Full and wrap-around: enqueue 8 entries without commit. Required:
  - fe_ready_and_o=0 and occupancy_o=8.
  - A 9th fe_v_i is dropped.
  - Dispatch all 8 and commit 3 → fe_ready_and_o=1 on the next cycle. Enqueue 3 more; their PCs appear after the wrap in order.
- Replay: 5 entries, dispatch 4, commit 1, then assert replay_v_i together with commit_v_i and dispatch_v_i. Required: the next isd_pc_o is entry #2, occupancy_o=3, and the same-cycle dispatch has no effect.
- Flush and illegal commit:
  - 4 entries, 2 dispatched, flush_v_i with fe_v_i=1 → next cycle isd_v_o=0, occupancy_o=0, and the new instruction is absent.
  - commit_v_i with no issued entry → err_o=1, pointers unchanged.
- Field extraction: enqueue instr 0x0C2081D3. Required: isd_rd_addr_o=3, isd_rs1_addr_o=1, isd_rs2_addr_o=2, isd_rs3_addr_o=1.
- Asynchronous reset mid-operation: drop reset_n_i between clock edges while the queue holds 6 entries. Required: before the next edge, occupancy_o=0, isd_v_o=0, err_o=0.

Source files
------------

// File: rtl/bp_be_issue_queue.sv
// Speculative issue queue between the FE and the BE hazard detector.
// Entries are written at wptr, issued at rptr and retired at cptr, so a replay can rewind rptr to cptr.
module bp_be_issue_queue #(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = 39,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      fe_v_i,
    input  logic [31:0]               fe_instr_i,
    input  logic [vaddr_width_p-1:0]  fe_pc_i,
    output logic                      fe_ready_and_o,

    output logic                      isd_v_o,
    output logic [31:0]               isd_instr_o,
    output logic [vaddr_width_p-1:0]  isd_pc_o,
    output logic [4:0]                isd_rs1_addr_o,
    output logic [4:0]                isd_rs2_addr_o,
    output logic [4:0]                isd_rs3_addr_o,
    output logic [4:0]                isd_rd_addr_o,

    input  logic                      dispatch_v_i,
    input  logic                      commit_v_i,
    input  logic                      replay_v_i,
    input  logic                      flush_v_i,

    output logic [ptr_width_lp-1:0]   occupancy_o,
    output logic                      err_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;
    localparam int entry_width_lp = 32 + vaddr_width_p;

    logic [entry_width_lp-1:0] r_mem [els_p];
    logic [ptr_width_lp-1:0]   r_wptr, r_rptr, r_cptr;
    logic                      r_err;

    logic [ptr_width_lp-1:0]   w_occ;
    logic                      w_full;
    logic                      w_isd_v;
    logic                      w_enq;
    logic                      w_issue;
    logic                      w_commit;
    logic                      w_bad_commit;
    logic [ptr_width_lp-1:0]   w_wptr_nxt, w_rptr_nxt, w_cptr_nxt;
    logic [entry_width_lp-1:0] w_head;

    assign w_occ   = r_wptr - r_cptr;
    assign w_full  = (w_occ == ptr_width_lp'(els_p));
    assign w_isd_v = (r_rptr != r_wptr);

    // Full is judged on current occupancy; a same-cycle commit frees space only next cycle.
    assign w_enq        = fe_v_i & ~w_full & ~flush_v_i;
    assign w_issue      = dispatch_v_i & w_isd_v & ~replay_v_i & ~flush_v_i;
    assign w_commit     = commit_v_i & ~flush_v_i & (r_cptr != r_rptr);
    assign w_bad_commit = commit_v_i & ~flush_v_i & (r_cptr == r_rptr);

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cptr_nxt = r_cptr;
        if (flush_v_i) begin
            w_rptr_nxt = r_wptr;
            w_cptr_nxt = r_wptr;
        end else begin
            w_wptr_nxt = r_wptr + ptr_width_lp'(w_enq);
            w_cptr_nxt = r_cptr + ptr_width_lp'(w_commit);
            // Replay lands on the oldest entry still uncommitted after this cycle's commit.
            if (replay_v_i) w_rptr_nxt = w_cptr_nxt;
            else            w_rptr_nxt = r_rptr + ptr_width_lp'(w_issue);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cptr <= w_cptr_nxt;
            if (w_bad_commit) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr[idx_width_lp-1:0]] <= {fe_instr_i, fe_pc_i};
    end

    assign w_head = r_mem[r_rptr[idx_width_lp-1:0]];

    assign fe_ready_and_o = ~w_full;
    assign isd_v_o        = w_isd_v;
    assign isd_instr_o    = w_head[entry_width_lp-1:vaddr_width_p];
    assign isd_pc_o       = w_head[vaddr_width_p-1:0];
    assign isd_rs1_addr_o = isd_instr_o[19:15];
    assign isd_rs2_addr_o = isd_instr_o[24:20];
    assign isd_rs3_addr_o = isd_instr_o[31:27];
    assign isd_rd_addr_o  = isd_instr_o[11:7];
    assign occupancy_o    = w_occ;
    assign err_o          = r_err;

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Bench for bp_be_issue_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bp_be_issue_queue;

    localparam int VW = 39;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fe_v, disp, commit, replay, flush;
    logic [31:0]   fe_instr;
    logic [VW-1:0] fe_pc;
    logic          fe_ready, isd_v, err;
    logic [31:0]   isd_instr;
    logic [VW-1:0] isd_pc;
    logic [4:0]    rs1, rs2, rs3, rd;
    logic [3:0]    occ;

    int errors = 0;
    int checks = 0;

    bp_be_issue_queue #(.els_p(8), .vaddr_width_p(VW)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .fe_v_i(fe_v), .fe_instr_i(fe_instr), .fe_pc_i(fe_pc), .fe_ready_and_o(fe_ready),
        .isd_v_o(isd_v), .isd_instr_o(isd_instr), .isd_pc_o(isd_pc),
        .isd_rs1_addr_o(rs1), .isd_rs2_addr_o(rs2), .isd_rs3_addr_o(rs3), .isd_rd_addr_o(rd),
        .dispatch_v_i(disp), .commit_v_i(commit), .replay_v_i(replay), .flush_v_i(flush),
        .occupancy_o(occ), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: all held entries oldest-first; the first m_iss of them are issued.
    logic [31:0]   m_instr [$];
    logic [VW-1:0] m_pc    [$];
    int            m_iss = 0;
    bit            m_err = 1'b0;
    int            m_sz;
    bit            m_full, m_hv;
    logic [31:0]   dummy_i;
    logic [VW-1:0] dummy_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_instr.delete();
            m_pc.delete();
            m_iss = 0;
            m_err = 1'b0;
        end else begin
            m_sz   = m_pc.size();
            m_full = (m_sz == 8);
            m_hv   = (m_iss < m_sz);
            if (flush) begin
                m_instr.delete();
                m_pc.delete();
                m_iss = 0;
            end else begin
                if (commit) begin
                    if (m_iss > 0) begin
                        dummy_i = m_instr.pop_front();
                        dummy_p = m_pc.pop_front();
                        m_iss   = m_iss - 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (replay)            m_iss = 0;
                else if (disp && m_hv) m_iss = m_iss + 1;
                if (fe_v && !m_full) begin
                    m_instr.push_back(fe_instr);
                    m_pc.push_back(fe_pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_ready", 64'(fe_ready), 64'(m_pc.size() != 8));
            chk("m_isd_v", 64'(isd_v), 64'(m_iss < m_pc.size()));
            chk("m_occ", 64'(occ), 64'(m_pc.size()));
            chk("m_err", 64'(err), 64'(m_err));
            if (m_iss < m_pc.size()) begin
                chk("m_pc", 64'(isd_pc), 64'(m_pc[m_iss]));
                chk("m_instr", 64'(isd_instr), 64'(m_instr[m_iss]));
                chk("m_rs1", 64'(rs1), 64'(m_instr[m_iss][19:15]));
                chk("m_rs2", 64'(rs2), 64'(m_instr[m_iss][24:20]));
                chk("m_rs3", 64'(rs3), 64'(m_instr[m_iss][31:27]));
                chk("m_rd", 64'(rd), 64'(m_instr[m_iss][11:7]));
            end
        end
    end

    // Drive one cycle of inputs (called just after a negedge) and return at the next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [VW-1:0] pc,
                        input logic d, input logic c, input logic r, input logic f);
        fe_v = v; fe_instr = ins; fe_pc = pc;
        disp = d; commit = c; replay = r; flush = f;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 32'h0, '0, 0, 0, 0, 0);
    endtask

    task automatic enq(input logic [VW-1:0] pc);
        step(1, 32'h13 | {pc[11:0], 20'h0}, pc, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        fe_v = 0; fe_instr = '0; fe_pc = '0; disp = 0; commit = 0; replay = 0; flush = 0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        run_cmp = 1'b1;
        chk("rst_ready", 64'(fe_ready), 64'd1);
        chk("rst_isd_v", 64'(isd_v), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering with dispatch held high.
        step(1, 32'h13, 39'h100, 1, 0, 0, 0);
        chk("ord_v1", 64'(isd_v), 64'd1);
        chk("ord_pc0", 64'(isd_pc), 64'h100);
        step(1, 32'h13, 39'h104, 1, 0, 0, 0);
        chk("ord_pc1", 64'(isd_pc), 64'h104);
        step(1, 32'h13, 39'h108, 1, 0, 0, 0);
        chk("ord_pc2", 64'(isd_pc), 64'h108);
        chk("ord_occ3", 64'(occ), 64'd3);
        step(0, 32'h0, '0, 1, 0, 0, 0);
        chk("ord_empty", 64'(isd_v), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, '0, 0, 1, 0, 0);
        chk("ord_drain", 64'(occ), 64'd0);

        // Full and wrap-around.
        for (int i = 0; i < 8; i++) enq(39'h200 + 39'(4 * i));
        chk("full_ready", 64'(fe_ready), 64'd0);
        chk("full_occ", 64'(occ), 64'd8);
        enq(39'h2FC);
        chk("full_drop", 64'(occ), 64'd8);
        for (int i = 0; i < 8; i++) step(0, 32'h0, '0, 1, 0, 0, 0);
        chk("full_alliss", 64'(isd_v), 64'd0);
        step(1, 32'h13, 39'h2F0, 0, 1, 0, 0);
        chk("full_cmt_noenq", 64'(occ), 64'd7);
        step(0, 32'h0, '0, 0, 1, 0, 0);
        step(0, 32'h0, '0, 0, 1, 0, 0);
        chk("full_ready2", 64'(fe_ready), 64'd1);
        chk("full_occ5", 64'(occ), 64'd5);
        enq(39'h300); enq(39'h304); enq(39'h308);
        chk("wrap_occ", 64'(occ), 64'd8);
        chk("wrap_pc0", 64'(isd_pc), 64'h300);
        step(0, 32'h0, '0, 1, 0, 0, 0);
        chk("wrap_pc1", 64'(isd_pc), 64'h304);
        step(0, 32'h0, '0, 1, 0, 0, 0);
        chk("wrap_pc2", 64'(isd_pc), 64'h308);
        step(0, 32'h0, '0, 0, 0, 0, 1);
        chk("wrap_flush", 64'(occ), 64'd0);

        // Replay with same-cycle commit and dispatch.
        for (int i = 0; i < 5; i++) enq(39'h400 + 39'(4 * i));
        for (int i = 0; i < 4; i++) step(0, 32'h0, '0, 1, 0, 0, 0);
        step(0, 32'h0, '0, 0, 1, 0, 0);
        step(0, 32'h0, '0, 1, 1, 1, 0);
        chk("rpl_pc", 64'(isd_pc), 64'h408);
        chk("rpl_occ", 64'(occ), 64'd3);
        step(0, 32'h0, '0, 0, 0, 0, 1);

        // Flush with enqueue, then an illegal commit.
        for (int i = 0; i < 4; i++) enq(39'h500 + 39'(4 * i));
        step(0, 32'h0, '0, 1, 0, 0, 0);
        step(0, 32'h0, '0, 1, 0, 0, 0);
        step(1, 32'h13, 39'h5F0, 0, 0, 0, 1);
        chk("fl_isd_v", 64'(isd_v), 64'd0);
        chk("fl_occ", 64'(occ), 64'd0);
        idle();
        chk("fl_absent", 64'(isd_v), 64'd0);
        step(0, 32'h0, '0, 0, 1, 0, 0);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_occ", 64'(occ), 64'd0);
        step(0, 32'h0, '0, 0, 0, 0, 1);
        chk("err_sticky", 64'(err), 64'd1);

        // Field extraction.
        step(1, 32'h0C2081D3, 39'h600, 0, 0, 0, 0);
        chk("fx_rd", 64'(rd), 64'd3);
        chk("fx_rs1", 64'(rs1), 64'd1);
        chk("fx_rs2", 64'(rs2), 64'd2);
        chk("fx_rs3", 64'(rs3), 64'd1);
        step(0, 32'h0, '0, 0, 0, 0, 1);

        // Asynchronous reset between edges with 6 entries held.
        for (int i = 0; i < 6; i++) enq(39'h700 + 39'(4 * i));
        chk("ar_pre_occ", 64'(occ), 64'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_occ", 64'(occ), 64'd0);
        chk("ar_isd_v", 64'(isd_v), 64'd0);
        chk("ar_err", 64'(err), 64'd0);
        chk("ar_ready", 64'(fe_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        enq(39'h800);
        chk("post_pc", 64'(isd_pc), 64'h800);
        idle();

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
